// File: rtl/load_unit.sv
// load_unit: multi-cycle RV32I load unit. Issues a word-aligned read over a
// request/response handshake, then extracts and extends the addressed lane.
// Misaligned or illegal loads fault immediately without touching memory, and
// a response that never arrives is aborted after TIMEOUT_CYCLES in WAIT.
module load_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [31:0] load_addr,
  input  logic [2:0]  load_control,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        load_done,
  output logic [31:0] load_data,
  output logic        load_fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT   = 2'b11;

  state_t      state;
  logic [31:0] addr_q;
  logic [1:0]  off_q;
  logic [2:0]  ctrl_q;
  logic [15:0] cnt;
  logic [31:0] data_q;
  logic        fault_q;
  logic [1:0]  cause_q;

  // Only LB, LH, LW, LBU and LHU are defined load encodings.
  function automatic logic is_illegal(input logic [2:0] ctrl);
    case (ctrl)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_illegal = 1'b0;
      default:                                is_illegal = 1'b1;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] off);
    case (ctrl)
      3'b001, 3'b101: is_misaligned = off[0];
      3'b010:         is_misaligned = (off != 2'b00);
      default:        is_misaligned = 1'b0;
    endcase
  endfunction

  // Select the addressed lane and sign- or zero-extend it to 32 bits.
  function automatic logic [31:0] extract(input logic [2:0] ctrl, input logic [1:0] off,
                                          input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = $signed(rdata[8*off +: 8]);
    h = off[1] ? $signed(rdata[31:16]) : $signed(rdata[15:0]);
    case (ctrl)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'd0, b};
      3'b101:  extract = {16'd0, h};
      default: extract = rdata;
    endcase
  endfunction

  // Load sequencing FSM; result and fault status are registered on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      ctrl_q  <= '0;
      cnt     <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_start) begin
            addr_q <= {load_addr[31:2], 2'b00};
            off_q  <= load_addr[1:0];
            ctrl_q <= load_control;
            if (is_illegal(load_control)) begin
              state   <= S_DONE;
              data_q  <= '0;
              fault_q <= 1'b1;
              cause_q <= CAUSE_ILLEGAL;
            end else if (is_misaligned(load_control, load_addr[1:0])) begin
              state   <= S_DONE;
              data_q  <= '0;
              fault_q <= 1'b1;
              cause_q <= CAUSE_MISALIGN;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            state <= S_WAIT;
            cnt   <= '0;
          end
        end
        S_WAIT: begin
          // A response in the expiry cycle still completes the load normally.
          if (mem_rvalid) begin
            state   <= S_DONE;
            data_q  <= extract(ctrl_q, off_q, mem_rdata);
            fault_q <= 1'b0;
            cause_q <= CAUSE_NONE;
          end else if (cnt == CNT_LAST) begin
            state   <= S_DONE;
            data_q  <= '0;
            fault_q <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          fault_q <= 1'b0;
          cause_q <= CAUSE_NONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake and status outputs decoded from state so the core stalls immediately.
  always_comb begin
    busy        = (state != S_IDLE);
    mem_req     = (state == S_REQ);
    load_done   = (state == S_DONE);
    mem_addr    = addr_q;
    load_data   = data_q;
    load_fault  = fault_q;
    fault_cause = cause_q;
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed testbench for load_unit with hand-computed expected values.
module tb_load_unit;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic [31:0] load_addr;
  logic [2:0]  load_control;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        load_done;
  logic [31:0] load_data;
  logic        load_fault;
  logic [1:0]  fault_cause;

  int n_checks = 0;
  int n_fail   = 0;

  load_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_addr    (load_addr),
    .load_control (load_control),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .load_done    (load_done),
    .load_data    (load_data),
    .load_fault   (load_fault),
    .fault_cause  (fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue a load with an immediate ready and response: start, REQ, WAIT, DONE.
  task automatic fast_load(input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] rdata);
    load_start = 1'b1; load_control = ctrl; load_addr = addr;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = rdata;
    cycle();
    load_start = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; load_start = 1'b0; load_addr = '0; load_control = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    cycle(); cycle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", load_done); end
    n_checks++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", load_data); end
    n_checks++; if ({load_fault, fault_cause} !== 3'b000) begin n_fail++; $display("FAIL reset_fault: got %b expected 000", {load_fault, fault_cause}); end
    reset = 1'b0;
  endtask

  task automatic test_lb();
    load_start = 1'b1; load_control = 3'b000; load_addr = 32'h0000_0103;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
    cycle();
    load_start = 1'b0;
    n_checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL lb_req: got req=%b busy=%b expected 1 1", mem_req, busy); end
    n_checks++; if (mem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL lb_mem_addr: got %h expected 00000100", mem_addr); end
    cycle();
    n_checks++; if (load_done !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL lb_wait: got done=%b req=%b expected 0 0", load_done, mem_req); end
    cycle();
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL lb_done: got %b expected 1", load_done); end
    n_checks++; if (load_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h expected ffffff80", load_data); end
    n_checks++; if (load_fault !== 1'b0) begin n_fail++; $display("FAIL lb_fault: got %b expected 0", load_fault); end
    mem_rvalid = 1'b0;
    cycle();
    n_checks++; if (load_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL lb_pulse: got done=%b busy=%b expected 0 0", load_done, busy); end
    n_checks++; if (load_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_hold: got %h expected ffffff80", load_data); end
  endtask

  task automatic test_half();
    fast_load(3'b101, 32'h0000_0202, 32'h9ABC_0001);
    n_checks++; if (load_done !== 1'b1 || load_data !== 32'h0000_9ABC) begin n_fail++; $display("FAIL lhu_data: got done=%b %h expected 1 00009abc", load_done, load_data); end
    mem_rvalid = 1'b0;
    cycle();
    fast_load(3'b001, 32'h0000_0202, 32'h9ABC_0001);
    n_checks++; if (load_done !== 1'b1 || load_data !== 32'hFFFF_9ABC) begin n_fail++; $display("FAIL lh_data: got done=%b %h expected 1 ffff9abc", load_done, load_data); end
    mem_rvalid = 1'b0;
    cycle();
  endtask

  task automatic test_faults();
    logic [2:0]  ctrl_t [4] = '{3'b010, 3'b011, 3'b111, 3'b001};
    logic [31:0] addr_t [4] = '{32'h301, 32'h300, 32'h301, 32'h203};
    logic [1:0]  exp_t  [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
    mem_ready = 1'b1; mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_start = 1'b1; load_control = ctrl_t[i]; load_addr = addr_t[i];
      cycle();
      load_start = 1'b0;
      n_checks++; if (load_done !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL fault%0d_done: got done=%b req=%b expected 1 0", i, load_done, mem_req); end
      n_checks++; if (load_fault !== 1'b1 || fault_cause !== exp_t[i]) begin n_fail++; $display("FAIL fault%0d_cause: got %b/%b expected 1/%b", i, load_fault, fault_cause, exp_t[i]); end
      n_checks++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL fault%0d_data: got %h expected 0", i, load_data); end
      cycle();
      n_checks++; if (mem_req !== 1'b0 || load_done !== 1'b0 || load_fault !== 1'b0) begin n_fail++; $display("FAIL fault%0d_after: got req=%b done=%b fault=%b expected 0 0 0", i, mem_req, load_done, load_fault); end
    end
  endtask

  task automatic test_stall();
    load_start = 1'b1; load_control = 3'b010; load_addr = 32'h0000_0400;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    cycle();
    // A second start while busy must be ignored.
    load_addr = 32'h0000_0808;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (mem_req !== 1'b1 || busy !== 1'b1 || mem_addr !== 32'h0000_0400) begin n_fail++; $display("FAIL stall_req%0d: got req=%b busy=%b addr=%h expected 1 1 00000400", i, mem_req, busy, mem_addr); end
      cycle();
      load_start = 1'b0;
    end
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL stall_still_req: got %b expected 1", mem_req); end
    mem_ready = 1'b1;
    cycle();
    mem_ready = 1'b0;
    n_checks++; if (mem_req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_wait: got req=%b busy=%b expected 0 1", mem_req, busy); end
    cycle();
    n_checks++; if (load_done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_wait2: got done=%b busy=%b expected 0 1", load_done, busy); end
    mem_rvalid = 1'b1;
    cycle();
    mem_rvalid = 1'b0;
    n_checks++; if (load_done !== 1'b1 || load_fault !== 1'b0 || load_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_data: got done=%b fault=%b %h expected 1 0 deadbeef", load_done, load_fault, load_data); end
    cycle();
    n_checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL stall_idle: got busy=%b req=%b expected 0 0 (no queued start)", busy, mem_req); end
  endtask

  task automatic test_timeout();
    load_start = 1'b1; load_control = 3'b010; load_addr = 32'h0000_0700;
    mem_ready = 1'b1; mem_rvalid = 1'b0;
    cycle();
    load_start = 1'b0;
    cycle();
    mem_ready = 1'b0;
    for (int w = 1; w <= 8; w++) begin
      cycle();
      if (w < 8) begin
        n_checks++; if (load_done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early%0d: got done=%b busy=%b expected 0 1", w, load_done, busy); end
      end else begin
        n_checks++; if (load_done !== 1'b1 || load_fault !== 1'b1 || fault_cause !== 2'b11) begin n_fail++; $display("FAIL timeout_fire: got done=%b fault=%b cause=%b expected 1 1 11", load_done, load_fault, fault_cause); end
        n_checks++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL timeout_data: got %h expected 0", load_data); end
      end
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (load_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL late_rvalid%0d: got done=%b busy=%b expected 0 0", i, load_done, busy); end
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_timeout_race();
    load_start = 1'b1; load_control = 3'b010; load_addr = 32'h0000_0704;
    mem_ready = 1'b1; mem_rvalid = 1'b0;
    cycle();
    load_start = 1'b0;
    cycle();
    mem_ready = 1'b0;
    for (int w = 1; w <= 7; w++) cycle();
    n_checks++; if (load_done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL race_pre: got done=%b busy=%b expected 0 1", load_done, busy); end
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    cycle();
    mem_rvalid = 1'b0;
    n_checks++; if (load_done !== 1'b1 || load_fault !== 1'b0 || load_data !== 32'h1234_5678) begin n_fail++; $display("FAIL race_win: got done=%b fault=%b %h expected 1 0 12345678", load_done, load_fault, load_data); end
    cycle();
  endtask

  task automatic test_reset_in_wait();
    load_start = 1'b1; load_control = 3'b010; load_addr = 32'h0000_0600;
    mem_ready = 1'b1; mem_rvalid = 1'b0;
    cycle();
    load_start = 1'b0;
    cycle();
    n_checks++; if (busy !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rstw_in_wait: got busy=%b req=%b expected 1 0", busy, mem_req); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL rstw_state: got busy=%b req=%b done=%b expected 0 0 0", busy, mem_req, load_done); end
    n_checks++; if (mem_addr !== 32'h0 || load_data !== 32'h0 || load_fault !== 1'b0 || fault_cause !== 2'b00) begin n_fail++; $display("FAIL rstw_regs: got addr=%h data=%h fault=%b cause=%b expected 0 0 0 00", mem_addr, load_data, load_fault, fault_cause); end
    mem_rvalid = 1'b1;
    cycle();
    mem_rvalid = 1'b0;
    n_checks++; if (load_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstw_stale: got done=%b busy=%b expected 0 0", load_done, busy); end
    fast_load(3'b100, 32'h0000_0501, 32'h0000_7F00);
    mem_rvalid = 1'b0;
    n_checks++; if (load_done !== 1'b1 || load_fault !== 1'b0 || load_data !== 32'h0000_007F) begin n_fail++; $display("FAIL rstw_lbu: got done=%b fault=%b %h expected 1 0 0000007f", load_done, load_fault, load_data); end
    cycle();
  endtask

  initial begin
    test_reset();
    test_lb();
    test_half();
    test_faults();
    test_stall();
    test_timeout();
    test_timeout_race();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
